bootprom_ctl: RTL and testbench



---
 rtl/bootprom_ctl.sv | 153 +++++++++++++++
 tb/tb_bootprom_ctl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bootprom_ctl.sv
// bootprom_ctl: bus-side sequencer for the Sun-2 boot PROM pair (27256 high
// and low byte parts). Decodes a 68010-style bus cycle to the PROM window,
// drives the shared PROM address/CE_n/OE_n for ACCESS_CYCLES clocks, latches
// both byte lanes into a word and acknowledges with DTACK_n. Writes to the
// window are acknowledged without touching the PROMs and flagged on wr_err.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   as_n, rw, uds_n,      68010 bus strobes / direction
//   lds_n, prom_sel, addr address decode hit and word address A15..A1
//   dtack_n, data_out,    acknowledge, read data and its bus-drive enable
//   data_oe, wr_err       one-clock write-attempt flag
//   prom_addr, prom_ce_n, shared PROM address and enables
//   prom_oe_n
//   prom_d_hi, prom_d_lo  PROM byte outputs
module bootprom_ctl #(
  parameter int ACCESS_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        as_n,
  input  logic        rw,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        prom_sel,
  input  logic [14:0] addr,
  output logic        dtack_n,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        wr_err,
  output logic [14:0] prom_addr,
  output logic        prom_ce_n,
  output logic        prom_oe_n,
  input  logic [7:0]  prom_d_hi,
  input  logic [7:0]  prom_d_lo
);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    ACK,
    WACK,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dtack_d;
  logic [15:0]        data_d;
  logic               data_oe_d;
  logic               wr_err_d;
  logic [14:0]        prom_addr_d;
  logic               prom_ce_d;
  logic               prom_oe_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dtack_n   <= 1'b1;
      data_out  <= '1;
      data_oe   <= 1'b0;
      wr_err    <= 1'b0;
      prom_addr <= '0;
      prom_ce_n <= 1'b1;
      prom_oe_n <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dtack_n   <= dtack_d;
      data_out  <= data_d;
      data_oe   <= data_oe_d;
      wr_err    <= wr_err_d;
      prom_addr <= prom_addr_d;
      prom_ce_n <= prom_ce_d;
      prom_oe_n <= prom_oe_d;
    end
  end

  // All outputs are registered: next values are computed here and hold by
  // default, so each state only lists what it changes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dtack_d     = dtack_n;
    data_d      = data_out;
    data_oe_d   = data_oe;
    wr_err_d    = 1'b0;
    prom_addr_d = prom_addr;
    prom_ce_d   = prom_ce_n;
    prom_oe_d   = prom_oe_n;

    unique case (state_q)
      IDLE: begin
        if (!as_n && prom_sel) begin
          if (rw) begin
            prom_addr_d = addr;
            cnt_d       = CNT_LOAD;
            prom_ce_d   = 1'b0;
            prom_oe_d   = 1'b0;
            state_d     = ACCESS;
          end else begin
            wr_err_d = 1'b1;
            state_d  = WACK;
          end
        end
      end

      ACCESS: begin
        // A dropped strobe wins over a capture due on the same clock.
        if (as_n) begin
          prom_ce_d = 1'b1;
          prom_oe_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == '0) begin
          data_d    = {(uds_n ? 8'hFF : prom_d_hi), (lds_n ? 8'hFF : prom_d_lo)};
          dtack_d   = 1'b0;
          data_oe_d = 1'b1;
          prom_ce_d = 1'b1;
          prom_oe_d = 1'b1;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ACK: begin
        if (as_n) begin
          dtack_d   = 1'b1;
          data_oe_d = 1'b0;
          state_d   = RELEASE;
        end
      end

      WACK: begin
        if (as_n) begin
          dtack_d = 1'b1;
          state_d = RELEASE;
        end else begin
          dtack_d = 1'b0;
        end
      end

      RELEASE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bootprom_ctl.sv
// Self-checking bench for bootprom_ctl. A transaction-level model predicts
// each bus cycle's visible timeline (decode, access window, acknowledge,
// release) and the captured word from the strobes; a second instance with
// ACCESS_CYCLES=1 covers the minimum-latency case.
module tb_bootprom_ctl;

  localparam int AC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        as_n = 1'b1;
  logic        rw = 1'b1;
  logic        uds_n = 1'b1;
  logic        lds_n = 1'b1;
  logic        prom_sel = 1'b0;
  logic [14:0] addr = '0;
  logic [7:0]  prom_d_hi = '0;
  logic [7:0]  prom_d_lo = '0;

  logic        dtack_n, data_oe, wr_err, prom_ce_n, prom_oe_n;
  logic [15:0] data_out;
  logic [14:0] prom_addr;

  logic        d1_dtack_n, d1_data_oe, d1_wr_err, d1_prom_ce_n, d1_prom_oe_n;
  logic [15:0] d1_data_out;
  logic [14:0] d1_prom_addr;

  int total = 0;
  int bad   = 0;

  // Model state carried between transactions.
  logic [15:0] exp_data = 16'hFFFF;
  logic [14:0] exp_addr = '0;
  bit          rel_pending = 1'b0;

  bootprom_ctl #(.ACCESS_CYCLES(AC), .CNT_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .rw(rw), .uds_n(uds_n),
    .lds_n(lds_n), .prom_sel(prom_sel), .addr(addr), .dtack_n(dtack_n),
    .data_out(data_out), .data_oe(data_oe), .wr_err(wr_err),
    .prom_addr(prom_addr), .prom_ce_n(prom_ce_n), .prom_oe_n(prom_oe_n),
    .prom_d_hi(prom_d_hi), .prom_d_lo(prom_d_lo)
  );

  bootprom_ctl #(.ACCESS_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .rw(rw), .uds_n(uds_n),
    .lds_n(lds_n), .prom_sel(prom_sel), .addr(addr), .dtack_n(d1_dtack_n),
    .data_out(d1_data_out), .data_oe(d1_data_oe), .wr_err(d1_wr_err),
    .prom_addr(d1_prom_addr), .prom_ce_n(d1_prom_ce_n), .prom_oe_n(d1_prom_oe_n),
    .prom_d_hi(prom_d_hi), .prom_d_lo(prom_d_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dtack"}, 32'(dtack_n), 1);
    check({tag, "_ce"}, 32'(prom_ce_n), 1);
    check({tag, "_oe"}, 32'(prom_oe_n), 1);
    check({tag, "_doe"}, 32'(data_oe), 0);
    check({tag, "_data"}, 32'(data_out), 32'(exp_data));
    check({tag, "_addr"}, 32'(prom_addr), 32'(exp_addr));
  endtask

  // Edge out of RELEASE: the strobe is already low but must not be decoded.
  task automatic skip_release(input string tag);
    if (rel_pending) begin
      tick();
      check_idle_outputs({tag, "_rel"});
      check({tag, "_rel_werr"}, 32'(wr_err), 0);
      rel_pending = 1'b0;
    end
  endtask

  // abort_at: ACCESS clock (1..AC) on which as_n is seen high, 0 = none.
  task automatic bus_read(input logic [14:0] a, input logic [7:0] hi, input logic [7:0] lo,
                          input logic u, input logic l, input int abort_at, input int hold);
    logic [15:0] w;
    as_n = 1'b0; rw = 1'b1; prom_sel = 1'b1; addr = a; uds_n = u; lds_n = l;
    prom_d_hi = 8'($urandom); prom_d_lo = 8'($urandom);
    skip_release("rd");
    tick();
    exp_addr = a;
    check("rd_dec_ce", 32'(prom_ce_n), 0);
    check("rd_dec_oe", 32'(prom_oe_n), 0);
    check("rd_dec_addr", 32'(prom_addr), 32'(a));
    check("rd_dec_dtack", 32'(dtack_n), 1);
    check("rd_dec_werr", 32'(wr_err), 0);
    addr = 15'($urandom);
    for (int k = 1; k <= AC; k++) begin
      if (k == abort_at) as_n = 1'b1;
      if (k == AC) begin
        prom_d_hi = hi; prom_d_lo = lo;
      end else begin
        prom_d_hi = 8'($urandom); prom_d_lo = 8'($urandom);
        rw = 1'($urandom); prom_sel = 1'($urandom);
      end
      tick();
      if (k == abort_at) begin
        check_idle_outputs("abort");
        tick();
        check_idle_outputs("abort_after");
        rel_pending = 1'b0;
        return;
      end
      if (k < AC) begin
        check("rd_acc_ce", 32'(prom_ce_n), 0);
        check("rd_acc_dtack", 32'(dtack_n), 1);
        check("rd_acc_addr", 32'(prom_addr), 32'(a));
      end
    end
    w = {(u ? 8'hFF : hi), (l ? 8'hFF : lo)};
    exp_data = w;
    check("rd_ack_dtack", 32'(dtack_n), 0);
    check("rd_ack_doe", 32'(data_oe), 1);
    check("rd_ack_data", 32'(data_out), 32'(w));
    check("rd_ack_ce", 32'(prom_ce_n), 1);
    check("rd_ack_oe", 32'(prom_oe_n), 1);
    for (int h = 0; h < hold; h++) begin
      prom_d_hi = 8'($urandom); prom_d_lo = 8'($urandom);
      tick();
      check("rd_hold_dtack", 32'(dtack_n), 0);
      check("rd_hold_data", 32'(data_out), 32'(w));
    end
    as_n = 1'b1;
    tick();
    check_idle_outputs("rd_end");
    rel_pending = 1'b1;
  endtask

  task automatic bus_write(input logic [14:0] a, input int hold);
    as_n = 1'b0; rw = 1'b0; prom_sel = 1'b1; addr = a;
    skip_release("wr");
    tick();
    check("wr_pulse", 32'(wr_err), 1);
    check_idle_outputs("wr_dec");
    rw = 1'($urandom); prom_sel = 1'($urandom);
    tick();
    check("wr_pulse_end", 32'(wr_err), 0);
    check("wr_dtack", 32'(dtack_n), 0);
    check("wr_ce", 32'(prom_ce_n), 1);
    check("wr_doe", 32'(data_oe), 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("wr_hold_dtack", 32'(dtack_n), 0);
      check("wr_hold_ce", 32'(prom_ce_n), 1);
    end
    as_n = 1'b1;
    tick();
    check_idle_outputs("wr_end");
    rel_pending = 1'b1;
  endtask

  task automatic bus_other(input int n);
    as_n = 1'b0; prom_sel = 1'b0; rw = 1'($urandom); addr = 15'($urandom);
    for (int i = 0; i < n; i++) begin
      tick();
      check_idle_outputs("nosel");
      check("nosel_werr", 32'(wr_err), 0);
    end
    as_n = 1'b1;
    tick();
    check_idle_outputs("nosel_end");
    rel_pending = 1'b0;
  endtask

  task automatic idle_tick();
    as_n = 1'b1;
    tick();
    check_idle_outputs("idle");
    rel_pending = 1'b0;
  endtask

  initial begin
    // Reset values.
    reset_n = 1'b0;
    tick();
    tick();
    check_idle_outputs("rst");
    check("rst_werr", 32'(wr_err), 0);
    reset_n = 1'b1;
    idle_tick();

    // Minimum latency instance alongside the default one.
    as_n = 1'b0; rw = 1'b1; prom_sel = 1'b1; addr = 15'h2AAA;
    uds_n = 1'b0; lds_n = 1'b0; prom_d_hi = 8'h12; prom_d_lo = 8'h34;
    tick();
    check("ac1_dec_ce", 32'(d1_prom_ce_n), 0);
    check("ac1_dec_dtack", 32'(d1_dtack_n), 1);
    tick();
    check("ac1_dtack", 32'(d1_dtack_n), 0);
    check("ac1_data", 32'(d1_data_out), 32'h1234);
    check("ac1_ce", 32'(d1_prom_ce_n), 1);
    check("ac1_main_wait", 32'(dtack_n), 1);
    tick();
    tick();
    tick();
    check("ac4_dtack", 32'(dtack_n), 0);
    check("ac4_data", 32'(data_out), 32'h1234);
    exp_data = 16'h1234; exp_addr = 15'h2AAA;
    as_n = 1'b1;
    tick();
    check("ac1_rel_dtack", 32'(d1_dtack_n), 1);
    check_idle_outputs("ac4_rel");
    idle_tick();

    // Directed cycles.
    bus_read(15'h0123, 8'h4E, 8'h71, 1'b0, 1'b0, 0, 0);
    idle_tick();
    bus_read(15'h0456, 8'hAB, 8'hCD, 1'b0, 1'b1, 0, 1);
    idle_tick();
    bus_write(15'h0789, 0);
    idle_tick();
    bus_read(15'h1111, 8'h55, 8'h66, 1'b0, 1'b0, 2, 0);
    bus_read(15'h0AAA, 8'h01, 8'h02, 1'b0, 1'b0, 0, 0);
    bus_read(15'h0BBB, 8'h03, 8'h04, 1'b0, 1'b0, 0, 0);
    bus_read(15'h7FFF, 8'h99, 8'h88, 1'b1, 1'b1, 0, 2);
    idle_tick();
    bus_read(15'h0CCC, 8'h9A, 8'hBC, 1'b1, 1'b0, AC, 0);

    // Reset in the middle of an access.
    as_n = 1'b0; rw = 1'b1; prom_sel = 1'b1; addr = 15'h3456;
    uds_n = 1'b0; lds_n = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0; as_n = 1'b1;
    tick();
    exp_data = 16'hFFFF; exp_addr = '0;
    check_idle_outputs("midrst");
    reset_n = 1'b1;
    idle_tick();
    bus_read(15'h2468, 8'hDE, 8'hAD, 1'b0, 1'b0, 0, 0);

    // Randomized mix of bus activity.
    for (int i = 0; i < 60; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        int ab;
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, AC)) : 0;
        bus_read(15'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 ab, int'($urandom_range(0, 3)));
      end else if (op <= 7) begin
        bus_write(15'($urandom), int'($urandom_range(0, 2)));
      end else if (op == 8) begin
        bus_other(int'($urandom_range(1, 3)));
      end else begin
        idle_tick();
      end
    end
    idle_tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
